// File: rtl/wbarb_pkg.sv
// wbarb_pkg: shared constants, state type and round-robin search used by wb_port_arbiter.
package wbarb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_result_t;

  // Scans ptr, ptr+1, ... ptr+7 (mod 8); walking offsets downward lets the
  // lowest offset from ptr overwrite any later candidate.
  function automatic rr_result_t rr_search(input logic [NUM_REQ-1:0] req,
                                           input logic [SEL_W-1:0]   ptr);
    rr_result_t       res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/demux1_8.sv
// demux1_8: routes a single input bit to one of eight outputs; the rest stay low.
module demux1_8 (
  input  logic       i,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  always_comb begin
    y      = '0;
    y[sel] = i;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter sharing one write-back port among eight requesters.
// Optional WBARB_LOCK_EN lets the granted requester hold the port for up to HOLD_MAX cycles.
//
// state | meaning
// IDLE  | no grant, waiting for any req
// GRANT | gnt[sel] high, port owned by requester sel
module wb_port_arbiter
  import wbarb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]          sel_o,
  output logic                      valid_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      busy_o
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] search_ptr;
  logic             hold_ok;
  rr_result_t       win;

`ifdef WBARB_LOCK_EN
  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX - 1);
  logic [3:0] hold_cnt;

  assign hold_ok = (state == GRANT) && lock[sel] && req[sel] && (hold_cnt < HOLD_LIM);

  // Any cycle that does not extend a hold either reloads a fresh winner or idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       hold_cnt <= '0;
    else if (hold_ok) hold_cnt <= hold_cnt + 4'd1;
    else              hold_cnt <= '0;
  end
`else
  logic [NUM_REQ-1:0] lock_unused;
  assign lock_unused = lock;
  assign hold_ok     = 1'b0;
`endif

  // Leaving GRANT searches from sel+1 in the same cycle so grants run back to back.
  assign search_ptr = (state == GRANT) ? sel + SEL_W'(1) : ptr;
  assign win        = rr_search(req, search_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (win.found) begin
          state_nxt = GRANT;
          sel_nxt   = win.idx;
        end
      end
      GRANT: begin
        if (!hold_ok) begin
          ptr_nxt = search_ptr;
          if (win.found) sel_nxt   = win.idx;
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o  = (state == GRANT);
  assign sel_o   = sel;
  assign valid_o = busy_o & req[sel];
  assign data_o  = valid_o ? data_i[sel*DATA_W +: DATA_W] : '0;

  demux1_8 u_demux (
    .i   (busy_o),
    .sel (sel),
    .y   (gnt)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed stimulus with a queue scoreboard; a negedge monitor
// pops one expected grant whenever the arbiter is busy. Covers both WBARB_LOCK_EN builds.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [7:0]  lock;
  logic [63:0] data_i;
  logic [7:0]  gnt;
  logic [2:0]  sel_o;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        busy_o;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

`ifdef WBARB_LOCK_EN
  localparam int SEQ_E [11] = '{5, 2, 2, 2, 2, 5, 2, 2, 2, 2, 5};
`else
  localparam int SEQ_E [11] = '{5, 2, 5, 2, 5, 2, 5, 2, 5, 2, 5};
`endif

  wb_port_arbiter #(.DATA_W(8), .HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .lock    (lock),
    .data_i  (data_i),
    .gnt     (gnt),
    .sel_o   (sel_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .busy_o  (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic push(input int idx, input logic v);
    exp_t e;
    e.gnt   = 8'h01 << idx;
    e.sel   = 3'(idx);
    e.valid = v;
    e.data  = v ? 8'(8'hA0 + idx) : 8'h00;
    q.push_back(e);
  endtask

  // Inputs change just after the falling edge, so they are stable across the
  // rising edge and still held when the monitor samples at the next falling edge.
  task automatic cyc(input logic [7:0] r, input logic [7:0] l);
    @(negedge clk);
    #1;
    req  = r;
    lock = l;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_gnt"},   32'(gnt),     32'h0);
    chk({tag, "_sel"},   32'(sel_o),   32'h0);
    chk({tag, "_valid"}, 32'(valid_o), 32'h0);
    chk({tag, "_data"},  32'(data_o),  32'h0);
    chk({tag, "_busy"},  32'(busy_o),  32'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n && !done) begin
      if (busy_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant actual gnt=%0h sel=%0d expected no grant", gnt, sel_o);
        end else begin
          mon_e = q.pop_front();
          chk("gnt",   32'(gnt),     32'(mon_e.gnt));
          chk("sel",   32'(sel_o),   32'(mon_e.sel));
          chk("valid", 32'(valid_o), 32'(mon_e.valid));
          chk("data",  32'(data_o),  32'(mon_e.data));
        end
      end else begin
        chk("idle_outputs", {23'h0, gnt, valid_o}, 32'h0);
        chk("idle_data", 32'(data_o), 32'h0);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    lock  = 8'h00;
    for (int k = 0; k < 8; k++) data_i[k*8 +: 8] = 8'(8'hA0 + k);

    // Reset held with every requester asking.
    repeat (2) @(negedge clk);
    rst_chk("reset");

    // Release into full load: one-cycle grants rotate 0..7 then wrap.
    cyc(8'hFF, 8'h00);
    rst_n = 1'b1;
    push(0, 1'b1);
    for (int k = 1; k < 10; k++) begin
      cyc(8'hFF, 8'h00);
      push(k % 8, 1'b1);
    end
    cyc(8'h00, 8'h00);
    cyc(8'h00, 8'h00);

    // Single request, then check the pointer moved past it (ptr=4 favours 4 over 3).
    cyc(8'h08, 8'h00); push(3, 1'b1);
    cyc(8'h00, 8'h00);
    cyc(8'h18, 8'h00); push(4, 1'b1);
    cyc(8'h00, 8'h00);

    // Wrap: after index 6 the search starts at 7 and wraps to 0.
    cyc(8'h40, 8'h00); push(6, 1'b1);
    cyc(8'h41, 8'h00); push(0, 1'b1);
    cyc(8'h41, 8'h00); push(6, 1'b1);
    cyc(8'h00, 8'h00);

    // Granted requester drops req mid-cycle: grant shown, no transfer, then moves on.
    cyc(8'h04, 8'h04); push(2, 1'b1);
    cyc(8'h04, 8'h04); push(2, 1'b0);
    @(posedge clk);
    #1;
    req = 8'h00;
    cyc(8'h10, 8'h04); push(4, 1'b1);
    cyc(8'h00, 8'h00);

    // Lock on requester 2 competing with 5, starting from ptr=5.
    for (int k = 0; k < 11; k++) begin
      cyc(8'h24, 8'h04);
      push(SEQ_E[k], 1'b1);
    end
    cyc(8'h00, 8'h00);

    // Reset pulse in the middle of a grant clears everything at once.
    cyc(8'h04, 8'h04); push(2, 1'b1);
    cyc(8'h04, 8'h04); push(2, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    rst_chk("midreset");

    // After release arbitration restarts from ptr=0.
    cyc(8'h24, 8'h00);
    rst_n = 1'b1;
    push(2, 1'b1);
    cyc(8'h24, 8'h00); push(5, 1'b1);
    cyc(8'h00, 8'h00);
    cyc(8'h00, 8'h00);
    @(negedge clk);

    chk("drain", 32'(q.size()), 32'h0);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
